// File: rtl/mips_pkg.sv
// Types and constants shared by the MIPS multiply/divide unit.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } mdu_op_t;

    typedef logic [1:0] mdu_state_t;

    localparam mdu_state_t ST_IDLE = 2'd0;
    localparam mdu_state_t ST_CALC = 2'd1;
    localparam mdu_state_t ST_FIX  = 2'd2;

    localparam int unsigned MDU_ITER = 32;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate used for the final sign correction.
module mdu_sign_fix #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? ({WIDTH{1'b0}} - value) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: one radix-2 step per cycle on
// operand magnitudes, then a single sign-correction cycle.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] LAST_STEP = 6'(MDU_ITER - 1);

    mdu_state_t         state_q, state_d;
    logic [5:0]         count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   rs_q, rs_d;
    logic               div_q, div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic             is_div, is_signed, rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign rs_neg    = is_signed & rs_data[WIDTH-1];
    assign rt_neg    = is_signed & rt_data[WIDTH-1];
    assign rs_mag    = rs_neg ? ({WIDTH{1'b0}} - rs_data) : rs_data;
    assign rt_mag    = rt_neg ? ({WIDTH{1'b0}} - rt_data) : rt_data;

    // Multiply step: acc = {partial product, remaining multiplier bits}, shifted right.
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] step_mul;

    assign addend   = acc_q[0] ? opnd_q : '0;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign step_mul = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: acc = {remainder, dividend/quotient}, shifted left.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   rem_diff;
    logic               qbit;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] step_div;

    assign rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_diff  = {1'b0, rem_shift} - {2'b00, opnd_q};
    assign qbit      = ~rem_diff[WIDTH+1];
    assign rem_next  = qbit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign step_div  = {rem_next, acc_q[WIDTH-2:0], qbit};

    // The remainder is always below the divisor, so this bit is zero whenever it is selected.
    logic unused_rem_bit;
    assign unused_rem_bit = rem_diff[WIDTH];

    logic [2*WIDTH-1:0] fix_in, fix_out;
    logic [WIDTH-1:0]   rem_fix;

    assign fix_in  = div_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;
    assign rem_fix = neg_hi_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH])
                              : acc_q[2*WIDTH-1:WIDTH];

    mdu_sign_fix #(
        .WIDTH (2 * WIDTH)
    ) u_sign_fix (
        .value  (fix_in),
        .negate (neg_lo_q),
        .result (fix_out)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        rs_d     = rs_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CALC;
                    count_d  = '0;
                    div_d    = is_div;
                    neg_lo_d = rs_neg ^ rt_neg;
                    neg_hi_d = is_div & rs_neg;
                    zero_d   = is_div && (rt_data == '0);
                    rs_d     = rs_data;
                    opnd_d   = is_div ? rt_mag : rs_mag;
                    acc_d    = {{WIDTH{1'b0}}, is_div ? rs_mag : rt_mag};
                end else begin
                    if (mthi) hi_d = rs_data;
                    if (mtlo) lo_d = rs_data;
                end
            end
            ST_CALC: begin
                acc_d   = div_q ? step_div : step_mul;
                count_d = count_q + 6'd1;
                if (count_q == LAST_STEP) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (zero_q) begin
                    hi_d = rs_q;
                    lo_d = '1;
                end else if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = fix_out[WIDTH-1:0];
                end else begin
                    {hi_d, lo_d} = fix_out;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            rs_q     <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            rs_q     <= rs_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus MT, busy-ignore and abort sequences.
module tb_mult_div_unit;
    import mips_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        start;
    mdu_op_t     op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit #(
        .WIDTH (32)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vec [NVEC];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Call at a falling edge. Returns done latency in edges after E0 (-1 on timeout), the
    // number of cycles where busy disagreed with the expected window, and HI/LO just after E0.
    task automatic run_op(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                          input logic mt_hi, input logic mt_lo, input logic poke,
                          output int lat, output int busy_bad,
                          output logic [31:0] hi_e0, output logic [31:0] lo_e0);
        lat      = -1;
        busy_bad = 0;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        start    = 1'b1;
        mthi     = mt_hi;
        mtlo     = mt_lo;
        @(posedge clock);
        #1;
        hi_e0 = hi;
        lo_e0 = lo;
        if (busy !== 1'b1) busy_bad++;
        @(negedge clock);
        start   = 1'b0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        for (int e = 1; e <= 40 && lat < 0; e++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) lat = e;
            if (busy !== (e < 33)) busy_bad++;
            if (poke && e >= 3 && e <= 6) begin
                start   = 1'b1;
                mthi    = 1'b1;
                mtlo    = 1'b1;
                op      = OP_DIVU;
                rs_data = 32'hDEADBEEF;
            end else begin
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
            end
        end
    endtask

    int          lat, busy_bad;
    logic [31:0] hi_e0, lo_e0;
    logic [31:0] last_lo;
    int          done_seen;

    initial begin
        vec[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vec[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vec[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vec[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vec[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vec[5]  = '{OP_MULT,  32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
        vec[6]  = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        vec[7]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vec[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vec[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vec[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vec[11] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vec[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        reset_n = 1'b0;
        start   = 1'b0;
        op      = OP_MULT;
        rs_data = '0;
        rt_data = '0;
        mthi    = 1'b0;
        mtlo    = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);

        // First start lands in the first cycle after reset release.
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            run_op(vec[i].op, vec[i].a, vec[i].b, 1'b0, 1'b0, 1'b0, lat, busy_bad, hi_e0, lo_e0);
            check($sformatf("vec%0d hi", i), 64'(hi), 64'(vec[i].exp_hi));
            check($sformatf("vec%0d lo", i), 64'(lo), 64'(vec[i].exp_lo));
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d busy window", i), 64'(busy_bad), 64'd0);
            @(negedge clock);
        end
        last_lo = vec[NVEC-1].exp_lo;

        // MT writes while idle.
        rs_data = 32'h12345678;
        mthi    = 1'b1;
        @(posedge clock);
        #1;
        check("mthi hi", 64'(hi), 64'h12345678);
        check("mthi lo held", 64'(lo), 64'(last_lo));
        @(negedge clock);
        mthi    = 1'b0;
        mtlo    = 1'b1;
        rs_data = 32'hAABBCCDD;
        @(posedge clock);
        #1;
        check("mtlo lo", 64'(lo), 64'hAABBCCDD);
        check("mtlo hi held", 64'(hi), 64'h12345678);
        @(negedge clock);
        mthi    = 1'b1;
        rs_data = 32'h0F0F0F0F;
        @(posedge clock);
        #1;
        check("mt both hi", 64'(hi), 64'h0F0F0F0F);
        check("mt both lo", 64'(lo), 64'h0F0F0F0F);
        @(negedge clock);
        mthi    = 1'b0;
        mtlo    = 1'b0;
        rs_data = 32'h55555555;
        @(posedge clock);
        #1;
        check("idle hold hi", 64'(hi), 64'h0F0F0F0F);
        check("idle hold lo", 64'(lo), 64'h0F0F0F0F);

        // Start together with MT writes, then start/mthi/mtlo pokes while busy.
        @(negedge clock);
        run_op(OP_MULTU, 32'd6, 32'd7, 1'b1, 1'b1, 1'b1, lat, busy_bad, hi_e0, lo_e0);
        check("start wins hi at E0", 64'(hi_e0), 64'h0F0F0F0F);
        check("start wins lo at E0", 64'(lo_e0), 64'h0F0F0F0F);
        check("poke hi", 64'(hi), 64'd0);
        check("poke lo", 64'(lo), 64'd42);
        check("poke latency", 64'(lat), 64'd33);
        check("poke busy window", 64'(busy_bad), 64'd0);
        @(negedge clock);
        @(posedge clock);
        #1;
        check("poke no restart", 64'(busy), 64'd0);

        // Abort at CALC iteration 10.
        @(negedge clock);
        op      = OP_MULTU;
        rs_data = 32'hFFFFFFFF;
        rt_data = 32'hFFFFFFFF;
        start   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clock);
        reset_n   = 1'b1;
        done_seen = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) done_seen++;
        end
        check("abort no done", 64'(done_seen), 64'd0);
        check("abort hi held", 64'(hi), 64'd0);

        @(negedge clock);
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, lat, busy_bad, hi_e0, lo_e0);
        check("post-abort hi", 64'(hi), 64'd2);
        check("post-abort lo", 64'(lo), 64'd14);
        check("post-abort latency", 64'(lat), 64'd33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

endmodule
